retire_serializer: RTL and testbench

- Sits directly downstream of the dual-issue core top and consumes its per-slot retire stream (update, pc, instr, reg, mem fields).
- Buffers up to IssueWidth retire records per cycle in a circular FIFO and drains them one record per cycle over a valid/ready interface, in program order.
- The output feeds the trace writer and the verification scoreboard. The block never back-pressures the core; overflow is reported, not stalled.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/retire_compactor.sv | 17 +
 rtl/retire_serializer.sv | 100 ++++++++++
 tb/tb_retire_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and the retire record carried from the core to the trace path.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int IssueWidth = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
    } retire_rec_t;

    localparam int RetireRecW = $bits(retire_rec_t);
endpackage

// File: rtl/retire_compactor.sv
// retire_compactor: packs the valid retire slots into write order, slot 0 before slot 1.
module retire_compactor
    import riscv_pkg::*;
(
    input  logic [IssueWidth-1:0] valid,
    input  retire_rec_t           rec [IssueWidth],
    output retire_rec_t           wr_rec [IssueWidth],
    output logic [IssueWidth-1:0] wr_slot,
    output logic [1:0]            n_in
);
    // A lone slot-1 record moves into the first write position.
    assign wr_rec[0]  = valid[0] ? rec[0] : rec[1];
    assign wr_slot[0] = !valid[0];
    assign wr_rec[1]  = rec[1];
    assign wr_slot[1] = 1'b1;
    assign n_in       = {1'b0, valid[0]} + {1'b0, valid[1]};
endmodule

// File: rtl/retire_serializer.sv
// retire_serializer: buffers up to two retire records per cycle and drains them one per cycle in order.
module retire_serializer
    import riscv_pkg::*;
#(
    parameter int Depth    = 16,
    parameter int CntWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   clear_i,
    input  logic [IssueWidth-1:0]  update_i,
    input  logic [XLEN-1:0]        pc_i       [IssueWidth],
    input  logic [XLEN-1:0]        instr_i    [IssueWidth],
    input  logic [4:0]             reg_addr_i [IssueWidth],
    input  logic [XLEN-1:0]        reg_data_i [IssueWidth],
    input  logic [XLEN-1:0]        mem_addr_i [IssueWidth],
    input  logic [XLEN-1:0]        mem_data_i [IssueWidth],
    input  logic [IssueWidth-1:0]  mem_wrt_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output retire_rec_t            out_rec_o,
    output logic                   out_slot_o,
    output logic [$clog2(Depth):0] level_o,
    output logic                   overflow_o,
    output logic [CntWidth-1:0]    drop_cnt_o,
    output logic [CntWidth-1:0]    retire_cnt_o
);
    localparam int AW = $clog2(Depth);

    retire_rec_t           rec    [IssueWidth];
    retire_rec_t           wr_rec [IssueWidth];
    logic [IssueWidth-1:0] wr_slot;
    logic [1:0]            n_in;
    retire_rec_t           mem    [Depth];
    logic [Depth-1:0]      slot_mem;
    logic [AW:0]           wptr, rptr, free, n_ext, acc, drop;
    logic [AW-1:0]         widx0, widx1, ridx;
    logic                  pop;

    for (genvar g = 0; g < IssueWidth; g++) begin : g_rec
        assign rec[g] = '{pc: pc_i[g], instr: instr_i[g], reg_addr: reg_addr_i[g],
                          reg_data: reg_data_i[g], mem_addr: mem_addr_i[g],
                          mem_data: mem_data_i[g], mem_wrt: mem_wrt_i[g]};
    end

    retire_compactor u_compactor (
        .valid   (update_i),
        .rec     (rec),
        .wr_rec  (wr_rec),
        .wr_slot (wr_slot),
        .n_in    (n_in)
    );

    // Capacity is judged on the start-of-cycle level; a same-cycle pop frees nothing.
    assign level_o     = wptr - rptr;
    assign out_valid_o = wptr != rptr;
    assign free        = (AW+1)'(Depth) - level_o;
    assign n_ext       = (AW+1)'(n_in);
    assign acc         = (n_ext > free) ? free : n_ext;
    assign drop        = n_ext - acc;
    assign pop         = out_valid_o & out_ready_i;
    assign widx0       = wptr[AW-1:0];
    assign widx1       = wptr[AW-1:0] + AW'(1);
    assign ridx        = rptr[AW-1:0];
    assign out_rec_o   = mem[ridx];
    assign out_slot_o  = slot_mem[ridx];

    always_ff @(posedge clk_i) begin
        if (|acc) begin
            mem[widx0]      <= wr_rec[0];
            slot_mem[widx0] <= wr_slot[0];
        end
        if (acc[1]) begin
            mem[widx1]      <= wr_rec[1];
            slot_mem[widx1] <= wr_slot[1];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr         <= '0;
            rptr         <= '0;
            overflow_o   <= 1'b0;
            drop_cnt_o   <= '0;
            retire_cnt_o <= '0;
        end else begin
            wptr <= wptr + acc;
            rptr <= rptr + (AW+1)'(pop);
            if (clear_i) begin
                overflow_o   <= 1'b0;
                drop_cnt_o   <= '0;
                retire_cnt_o <= '0;
            end else begin
                overflow_o   <= overflow_o | (|drop);
                drop_cnt_o   <= drop_cnt_o + CntWidth'(drop);
                retire_cnt_o <= retire_cnt_o + CntWidth'(acc);
            end
        end
    end
endmodule

// File: tb/tb_retire_serializer.sv
// tb_retire_serializer: directed and random checks of retire_serializer against a queue model.
module tb_retire_serializer;
    import riscv_pkg::*;

    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              clear = 1'b0;
    logic [1:0]        upd = '0;
    logic [XLEN-1:0]   pc [2], instr [2], rd [2], ma [2], md [2];
    logic [4:0]        ra [2];
    logic [1:0]        mw = '0;
    logic              ready = 1'b0;
    logic              out_valid;
    retire_rec_t       out_rec;
    logic              out_slot;
    logic [4:0]        level;
    logic              overflow;
    logic [31:0]       drop_cnt, retire_cnt;

    typedef struct {
        retire_rec_t r;
        logic        s;
    } ent_t;

    ent_t        q[$];
    int unsigned m_ret, m_drop;
    bit          m_ovf;
    bit          chk_en = 1'b0;
    int          n_chk = 0, n_fail = 0;

    retire_serializer #(.Depth(DEPTH), .CntWidth(32)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .clear_i      (clear),
        .update_i     (upd),
        .pc_i         (pc),
        .instr_i      (instr),
        .reg_addr_i   (ra),
        .reg_data_i   (rd),
        .mem_addr_i   (ma),
        .mem_data_i   (md),
        .mem_wrt_i    (mw),
        .out_valid_o  (out_valid),
        .out_ready_i  (ready),
        .out_rec_o    (out_rec),
        .out_slot_o   (out_slot),
        .level_o      (level),
        .overflow_o   (overflow),
        .drop_cnt_o   (drop_cnt),
        .retire_cnt_o (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic retire_rec_t slot_rec(int i);
        return '{pc: pc[i], instr: instr[i], reg_addr: ra[i], reg_data: rd[i],
                 mem_addr: ma[i], mem_data: md[i], mem_wrt: mw[i]};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ret = 0;
        m_drop = 0;
        m_ovf = 0;
    endfunction

    // Model of one clock edge: capacity from the pre-edge occupancy, pop and push both honoured.
    function automatic void model_step();
        ent_t in_list[$];
        int   free = DEPTH - q.size();
        int   keep;
        bit   do_pop = (q.size() != 0) && ready;
        for (int i = 0; i < 2; i++)
            if (upd[i]) in_list.push_back('{r: slot_rec(i), s: 1'(i)});
        keep = (in_list.size() < free) ? in_list.size() : free;
        if (do_pop) void'(q.pop_front());
        for (int i = 0; i < keep; i++) q.push_back(in_list[i]);
        if (clear) begin
            m_ret = 0;
            m_drop = 0;
            m_ovf = 0;
        end else begin
            m_ret += keep;
            m_drop += in_list.size() - keep;
            if (in_list.size() > keep) m_ovf = 1;
        end
    endfunction

    task automatic set_in(bit u0, bit u1, logic [31:0] p0, logic [31:0] p1, bit rdy, bit clr);
        upd = {u1, u0};
        pc[0] = p0;
        pc[1] = p1;
        for (int i = 0; i < 2; i++) begin
            instr[i] = $urandom;
            rd[i] = $urandom;
            ma[i] = $urandom;
            md[i] = $urandom;
            ra[i] = 5'($urandom);
        end
        mw = 2'($urandom);
        ready = rdy;
        clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 rstn = 1'b0;
        model_reset();
        #2 rstn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rstn && chk_en) begin
            chk("valid", out_valid, q.size() != 0);
            chk("level", level, q.size());
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("retire_cnt", retire_cnt, m_ret);
            if (q.size() != 0) begin
                chk("out_rec", out_rec, q[0].r);
                chk("out_slot", out_slot, q[0].s);
            end
        end
    end

    initial begin
        int thresh;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_counters", {overflow, drop_cnt, retire_cnt}, 0);
        #3 rstn = 1'b1;
        chk_en = 1'b1;

        // Dual push drains in slot order.
        set_in(1, 1, 32'h0, 32'h4, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t1_pc0", out_rec.pc, 32'h0);
        chk("t1_slot0", out_slot, 0);
        tick();
        @(negedge clk);
        chk("t1_pc4", out_rec.pc, 32'h4);
        chk("t1_slot1", out_slot, 1);
        tick();
        @(negedge clk);
        chk("t1_empty", out_valid, 0);
        chk("t1_retire", retire_cnt, 2);
        chk("t1_level", level, 0);

        // Only slot 1 valid takes the first position.
        set_in(0, 1, 32'h0, 32'h8, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_pc", out_rec.pc, 32'h8);
        chk("t2_slot", out_slot, 1);
        chk("t2_level", level, 1);

        // Fill to full, then a whole dual push is dropped; clear keeps contents.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            set_in(1, 1, 32'(8 * i), 32'(8 * i + 4), 0, 0);
            tick();
        end
        @(negedge clk);
        chk("t3_full", level, 16);
        chk("t3_no_ovf", overflow, 0);
        set_in(1, 1, 32'h40, 32'h44, 0, 0);
        tick();
        @(negedge clk);
        chk("t3_drop", drop_cnt, 2);
        chk("t3_ovf", overflow, 1);
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_clr_ovf", overflow, 0);
        chk("t3_clr_level", level, 16);
        chk("t3_clr_head", out_rec.pc, 32'h0);

        // One free slot: slot 0 kept, slot 1 dropped, pop does not help.
        set_in(0, 0, 0, 0, 1, 0);
        tick();
        @(negedge clk);
        chk("t4_level15", level, 15);
        set_in(1, 1, 32'h100, 32'h104, 1, 0);
        tick();
        @(negedge clk);
        chk("t4_level", level, 15);
        chk("t4_drop", drop_cnt, 1);
        set_in(0, 0, 0, 0, 1, 0);
        repeat (16) tick();

        // Continuous dual push with draining wraps the pointers.
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            set_in(1, 1, 32'(8 * i), 32'(8 * i + 4), 1, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t5_total", drop_cnt + retire_cnt, 80);
        repeat (20) tick();

        // Asynchronous reset mid-cycle with five buffered records.
        reset_dut();
        set_in(1, 1, 32'h10, 32'h14, 0, 0);
        tick();
        tick();
        set_in(1, 0, 32'h18, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_level5", level, 5);
        @(posedge clk);
        model_step();
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_counters", {overflow, drop_cnt, retire_cnt}, 0);
        #1 rstn = 1'b1;

        // Random traffic with varying consumer pressure.
        thresh = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) thresh = $urandom_range(0, 100);
            set_in(1'($urandom), 1'($urandom), $urandom, $urandom,
                   $urandom_range(0, 99) < thresh, $urandom_range(0, 63) == 0);
            tick();
        end
        set_in(0, 0, 0, 0, 1, 0);
        repeat (20) tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
